pipeline_sequencer: RTL
=======================

Name: pipeline_sequencer

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline. It generates the enable and flush inputs for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches from cache hits, load-use hazards, EX-stage redirects and halt. It owns the halt-drain state machine and the stall/flush performance counters, and sits beside the datapath next to the hazard and forwarding logic.

Parameters:
CNT_W, 16, width of the saturating performance counters.

Ports:
CLK  in  1  clock; all state on rising edge
RST  in  1  asynchronous active-high reset
ihit  in  1  icache hit for the current PC fetch
dhit  in  1  dcache hit for the MEM-stage request
mem_dREN  in  1  MEM-stage load (EX/MEM latch output)
mem_dWEN  in  1  MEM-stage store
ex_dREN  in  1  EX-stage instruction is a load (ID/EX dREN_out)
ex_wsel  in  5  EX-stage destination register (ID/EX wsel_out)
id_rs  in  5  ID-stage rs field
id_rt  in  5  ID-stage rt field
id_uses_rt  in  1  ID instruction reads rt as a source
ex_redirect  in  1  taken branch or jump resolved in EX
id_halt  in  1  ID-stage instruction is HALT
wb_halt  in  1  MEM/WB halt_out
pc_en  out  1  PC load enable
ifid_en  out  1  IF/ID latch enable
ifid_flush  out  1  IF/ID load NOP
idex_en  out  1  ID/EX latch enable
idex_flush  out  1  ID/EX load NOP (drives ID_EX flush)
exmem_en  out  1  EX/MEM latch enable
memwb_en  out  1  MEM/WB latch enable
memwb_flush  out  1  MEM/WB load NOP
halt  out  1  sticky processor halt
stall_cnt  out  CNT_W  cycles with pc_en=0 outside HALTED, saturating
flush_cnt  out  CNT_W  ex_redirect events, saturating

Behaviour:
- The output decode is combinational from state and inputs. The state and counters are registered.
- RST: state=RUN, halt=0, counters=0.
- States:
  - RUN: normal operation.
  - DWAIT: a MEM request is outstanding.
  - DRAIN: a HALT was seen in ID and fetch is stopped.
  - HALTED: terminal.
- dmem_busy = (mem_dREN|mem_dWEN) & ~dhit.
- Priority per cycle, highest first:
  - 1. HALTED: all enables 0, all flushes 0, halt=1. Only RST exits this state.
  - 2. dmem_busy: pc/ifid/idex/exmem enables 0, memwb_en=1, memwb_flush=1 (bubble into WB, no double writeback). Next state is DWAIT. The prior state (RUN or DRAIN) is remembered in a 1-bit flag and restored on the cycle dmem_busy drops.
  - 3. ex_redirect: pc_en=1 (target loads regardless of ihit), ifid_flush=1, idex_flush=1, exmem_en=1, memwb_en=1. Redirect overrides load-use. Redirect in DRAIN returns to RUN, because the HALT is on the wrong path. flush_cnt increments.
  - 4. Load-use, when ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)): pc_en=0, ifid_en=0, idex_flush=1, EX/MEM and MEM/WB advance. The result is exactly one bubble, because the load leaves EX next cycle.
  - 5. ~ihit (RUN only): pc_en=0, ifid_flush=1, downstream latches advance.
  - 6. Otherwise all enables are 1 and all flushes are 0.
- id_halt in RUN with no higher-priority event: the HALT advances to ID/EX and the state becomes DRAIN.
- In DRAIN: pc_en=0 and ifid_flush=1 every cycle, and downstream latches advance per the rules above.
- wb_halt=1 enters HALTED on the next edge with halt=1. wb_halt takes precedence over every other event that cycle.
- ifid_en=1 whenever ifid_flush=1; a flush loads a NOP.
- stall_cnt: +1 per cycle with pc_en=0 in RUN, DWAIT or DRAIN. The counters saturate at all-ones.
- RST mid-DWAIT or mid-DRAIN: immediate return to RUN, counters cleared.

Decomposition:
- cpu_types_pkg gains `typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} seq_state_t`, plus regbits_t reuse for the register fields.
- Sub-module sat_counter (param W, inc, clear) is instantiated twice for the counters.
- Load-use compare stays inline.

Test Plan:
- Reset, then ihit=1 and no hazards: all enables 1, flushes 0, halt=0, counters 0.
- ex_dREN=1, ex_wsel=5, id_rs=5: one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. With ex_wsel=0 there is no stall.
- mem_dREN=1 with dhit low for 3 cycles: 3 cycles of frozen enables with memwb_flush=1, normal on the 4th cycle, stall_cnt=3.
- Load-use and ex_redirect in the same cycle: pc_en=1, ifid_flush=1, idex_flush=1, flush_cnt=1.
- id_halt in RUN: DRAIN with pc_en=0. Then wb_halt 3 cycles later: HALTED, halt=1, all enables 0 on every later cycle.
- id_halt followed by ex_redirect one cycle later: back to RUN, halt stays 0. Separately, drive stall_cnt to all-ones and add one more stall: the count holds at all-ones.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register-field type, sequencer state encoding and the
// per-cycle latch control bundle driven by the pipeline sequencer.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} seq_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
    logic memwb_flush;
  } latch_ctl_t;

  // Canned control patterns, one per priority outcome.
  localparam latch_ctl_t CTL_RUN      = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam latch_ctl_t CTL_OFF      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam latch_ctl_t CTL_BUSY     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam latch_ctl_t CTL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam latch_ctl_t CTL_LOAD_USE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  // Fetch held, NOP pushed into IF/ID, everything downstream advances.
  localparam latch_ctl_t CTL_BUBBLE   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async reset and synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush controller for the 5-stage pipeline: latch enables and flushes
// from cache hits, load-use, EX redirects and the halt-drain state machine.
module pipeline_sequencer
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_dREN,
  input  logic [4:0]       ex_wsel,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_redirect,
  input  logic             id_halt,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  seq_state_t state, state_n, mode;
  logic       drain_saved, drain_saved_n;
  latch_ctl_t ctl;
  logic       dmem_busy, load_use;
  logic       stall_inc, flush_inc;
  regbits_t   ex_dst;

  assign ex_dst    = ex_wsel;
  assign dmem_busy = (mem_dREN | mem_dWEN) & ~dhit;
  assign load_use  = ex_dREN & (ex_dst != '0) &
                     ((ex_dst == id_rs) | (id_uses_rt & (ex_dst == id_rt)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= RUN;
      drain_saved <= 1'b0;
    end else begin
      state       <= state_n;
      drain_saved <= drain_saved_n;
    end
  end

  always_comb begin
    ctl           = CTL_RUN;
    state_n       = state;
    drain_saved_n = drain_saved;
    flush_inc     = 1'b0;
    // While waiting on dmem, behave as the state we left once the wait ends.
    mode          = (state == DWAIT) ? (drain_saved ? DRAIN : RUN) : state;

    if (state == HALTED) begin
      ctl = CTL_OFF;
    end else if (dmem_busy) begin
      ctl     = CTL_BUSY;
      state_n = DWAIT;
      if (state != DWAIT)
        drain_saved_n = (state == DRAIN);
    end else if (ex_redirect) begin
      // A HALT being drained sits on the wrong path, so abandon the drain.
      ctl       = CTL_REDIRECT;
      state_n   = RUN;
      flush_inc = 1'b1;
    end else if (load_use) begin
      ctl     = CTL_LOAD_USE;
      state_n = mode;
    end else if (mode == DRAIN) begin
      ctl     = CTL_BUBBLE;
      state_n = DRAIN;
    end else begin
      if (!ihit)
        ctl = CTL_BUBBLE;
      state_n = id_halt ? DRAIN : RUN;
    end

    if ((state != HALTED) && wb_halt)
      state_n = HALTED;

    stall_inc = (state != HALTED) && !ctl.pc_en;
  end

  assign pc_en       = ctl.pc_en;
  assign ifid_en     = ctl.ifid_en;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_en     = ctl.idex_en;
  assign idex_flush  = ctl.idex_flush;
  assign exmem_en    = ctl.exmem_en;
  assign memwb_en    = ctl.memwb_en;
  assign memwb_flush = ctl.memwb_flush;
  assign halt        = (state == HALTED);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (stall_inc),
    .clear (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (flush_inc),
    .clear (1'b0),
    .count (flush_cnt)
  );

endmodule
